// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding and
// the bit-counter width helper.
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Counter width for a WIDTH-cycle sequence; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell shared by every bit position of the serial add.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: walks one full_adder over WIDTH cycles, LSB
// first, with a start/ready handshake and a one-cycle done pulse.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int unsigned    CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH:0]   sum_ext;
  logic             last_bit;

  full_adder u_full_adder (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .c_in  (carry_q),
    .sum   (fa_s),
    .c_out (fa_co)
  );

  // New sum bit enters at the MSB; slicing the extended vector also works for WIDTH=1.
  assign sum_ext  = {fa_s, sum_sh_q};
  assign last_bit = (cnt_q == CntLast);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; the unused encoding falls back to idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StShift;
      StShift: if (last_bit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs decoded from the current state only.
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      StIdle:  ready = 1'b1;
      StShift: busy  = 1'b1;
      StDone:  done  = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // Datapath next state: load on accept, shift one bit per busy cycle.
  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    c_out_d  = c_out_q;
    if (ready && start) begin
      a_sh_d  = a;
      b_sh_d  = b;
      carry_d = c_in;
      cnt_d   = '0;
    end else if (busy) begin
      a_sh_d   = a_sh_q >> 1;
      b_sh_d   = b_sh_q >> 1;
      sum_sh_d = sum_ext[WIDTH:1];
      carry_d  = fa_co;
      cnt_d    = cnt_q + 1'b1;
      // Result registers change only when the final bit lands, so the
      // previous result stays visible for the whole run.
      if (last_bit) begin
        sum_d   = sum_ext[WIDTH:1];
        c_out_d = fa_co;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      c_out_q  <= 1'b0;
    end else begin
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      c_out_q  <= c_out_d;
    end
  end

  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic       ready8, busy8, done8, co8;
  logic [7:0] sum8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       cin1 = 1'b0;
  logic       ready1, busy1, done1, co1;
  logic [0:0] sum1;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .c_in  (cin8),
    .ready (ready8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .c_out (co8)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .c_in  (cin1),
    .ready (ready1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .c_out (co1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 transaction; operands are scrambled right after accept.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic c, input logic [7:0] exp_sum, input logic exp_co);
    int lat;
    @(posedge clk); #1;
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = ~a; b8 = ~b; cin8 = ~c;
    check({tag, ".busy"}, {31'd0, busy8}, 32'd1);
    lat = 0;
    while (!done8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, lat, 32'd8);
    check({tag, ".sum"}, {24'd0, sum8}, {24'd0, exp_sum});
    check({tag, ".c_out"}, {31'd0, co8}, {31'd0, exp_co});
    @(posedge clk); #1;
    check({tag, ".done_clear"}, {31'd0, done8}, 32'd0);
    check({tag, ".ready_back"}, {31'd0, ready8}, 32'd1);
  endtask

  // One WIDTH=1 transaction; expected value is {c_out, sum}.
  task automatic run1(input string tag, input logic a, input logic b, input logic c,
                      input logic [1:0] exp);
    int lat;
    @(posedge clk); #1;
    a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; a1 = ~a; b1 = ~b; cin1 = ~c;
    lat = 0;
    while (!done1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, lat, 32'd1);
    check({tag, ".result"}, {30'd0, co1, sum1}, {30'd0, exp});
    @(posedge clk); #1;
  endtask

  initial begin
    int         dones;
    int         done_edge;
    int         rdy_bad;
    logic [7:0] s_cap;
    logic       co_cap;
    logic [1:0] fa_tab [8];
    logic [2:0] v;

    // {c_out,sum} for index {a,b,c_in}
    fa_tab = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

    #12;
    check("rst.ready8", {31'd0, ready8}, 32'd1);
    check("rst.busy8", {31'd0, busy8}, 32'd0);
    check("rst.done8", {31'd0, done8}, 32'd0);
    check("rst.sum8", {24'd0, sum8}, 32'd0);
    check("rst.co8", {31'd0, co8}, 32'd0);
    check("rst.ready1", {31'd0, ready1}, 32'd1);
    rst_n = 1'b1;

    run8("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    run8("3c_0f", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);
    run8("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run8("a5_5a_c", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);

    // Start ignored while busy; operand changes mid-run ignored.
    @(posedge clk); #1;
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    dones = 0; done_edge = 0; rdy_bad = 0; s_cap = '0; co_cap = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      if (e == 2) begin
        a8 = 8'hFF; b8 = 8'h77; start8 = 1'b1;
      end
      if (e == 3) start8 = 1'b0;
      if (e <= 8 && ready8) rdy_bad++;
      if (done8) begin
        dones++; done_edge = e; s_cap = sum8; co_cap = co8;
      end
    end
    check("busy_start.dones", dones, 32'd1);
    check("busy_start.done_edge", done_edge, 32'd8);
    check("busy_start.ready_low", rdy_bad, 32'd0);
    check("busy_start.sum", {24'd0, s_cap}, 32'h02);
    check("busy_start.c_out", {31'd0, co_cap}, 32'd0);

    // Reset in the middle of an FF+FF run.
    @(posedge clk); #1;
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    check("mid_rst.busy_before", {31'd0, busy8}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst.sum", {24'd0, sum8}, 32'd0);
    check("mid_rst.c_out", {31'd0, co8}, 32'd0);
    check("mid_rst.ready", {31'd0, ready8}, 32'd1);
    check("mid_rst.busy", {31'd0, busy8}, 32'd0);
    dones = 0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      if (e == 2) rst_n = 1'b1;
      if (done8) dones++;
    end
    check("mid_rst.no_done", dones, 32'd0);
    run8("10_20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);

    // WIDTH=1 truth table.
    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      run1($sformatf("w1_%0d", i), v[2], v[1], v[0], fa_tab[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
